// File: rtl/pipe_div_pkg.sv
// Shared constants and state encoding for the iterative radix-2 divider.
package pipe_div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_div_if.sv
// Request/result bundle between the EX stage and the divider.
interface pipe_div_if import pipe_div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic             start;
  logic             sign;
  logic             flush;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             done;

  modport master (
    output start, sign, flush, dividend, divisor,
    input  q, r, busy, done
  );

  modport slave (
    input  start, sign, flush, dividend, divisor,
    output q, r, busy, done
  );

endinterface

// File: rtl/pipe_div_unit_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The running remainder is always below the divisor, so WIDTH+1 bits hold the shift.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, divisor_i};
    q_bit_o = (shifted >= {1'b0, divisor_i});
    rem_o   = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/pipe_div_unit.sv
// Iterative signed/unsigned divider: IDLE -> RUN (ITER steps) -> FIX (sign correction, result write).
module pipe_div_unit import pipe_div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH,
  parameter int ITER  = DIV_ITER
) (
  input  logic        clk,
  input  logic        rst,
  pipe_div_if.slave   bus
);

  localparam int CW = $clog2(ITER);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div_zero_q, div_zero_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q_bit;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q_bit)
  );

  // NOTE: every _d gets its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    q_d        = q_q;
    r_d        = r_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          state_d    = S_RUN;
          count_d    = '0;
          rem_d      = '0;
          dvd_d      = (bus.sign && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
          dvs_d      = (bus.sign && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
          neg_quo_d  = bus.sign & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
          neg_rem_d  = bus.sign & bus.dividend[WIDTH-1];
          div_zero_d = (bus.divisor == '0);
        end
      end
      S_RUN: begin
        // Quotient bits shift into the low end as dividend bits leave the top.
        rem_d   = step_rem;
        dvd_d   = {dvd_q[WIDTH-2:0], step_q_bit};
        count_d = count_q + 1'b1;
        if (count_q == CW'(ITER - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        // With a zero divisor the remainder is |dividend|; negating it restores the raw dividend.
        q_d     = div_zero_q ? WIDTH'(DIV_BY_ZERO_Q) : (neg_quo_q ? -dvd_q : dvd_q);
        r_d     = neg_rem_q ? -rem_q : rem_q;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && bus.flush) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      q_d     = q_q;
      r_d     = r_q;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      q_q        <= '0;
      r_q        <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      q_q        <= q_d;
      r_q        <= r_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.q    = q_q;
  assign bus.r    = r_q;

endmodule

// File: tb/tb_pipe_div_unit.sv
// Scoreboard bench for pipe_div_unit: expectations queued at issue, popped on each done pulse.
module tb_pipe_div_unit;
  import pipe_div_pkg::*;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  pipe_div_if #(.WIDTH(32)) bus ();

  pipe_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t        e;
    logic [31:0] ma, mb, qm, rm;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
      return e;
    end
    ma  = (s && a[31]) ? -a : a;
    mb  = (s && b[31]) ? -b : b;
    qm  = ma / mb;
    rm  = ma % mb;
    e.q = (s && (a[31] ^ b[31])) ? -qm : qm;
    e.r = (s && a[31]) ? -rm : rm;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input bit push, input logic [31:0] eq, input logic [31:0] er);
    exp_t e;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    bus.sign     = s;
    if (push) begin
      e.q = eq;
      e.r = er;
      sb.push_back(e);
    end
  endtask

  // Called in the accept cycle T; returns in cycle T+34. Optionally re-requests at T+poke.
  task automatic expect_run(input int poke);
    for (int i = 1; i <= 33; i++) begin
      step();
      bus.start = (i == poke);
      if (i == poke) begin
        bus.dividend = 32'h0000_DEAD;
        bus.divisor  = 32'd3;
      end
      check($sformatf("busy_c%0d", i), bus.busy, 1'b1);
      check($sformatf("nodone_c%0d", i), bus.done, 1'b0);
    end
    step();
    bus.start = 1'b0;
    check("done_c34", bus.done, 1'b1);
    check("busy_c34", bus.busy, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        check("spurious_done", bus.done, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("q", bus.q, e.q);
        check("r", bus.r, e.r);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    bus.start    = 1'b0;
    bus.sign     = 1'b0;
    bus.flush    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_q", bus.q, 32'd0);
    check("rst_r", bus.r, 32'd0);

    issue(32'd100, 32'd7, 1'b0, 1, 32'd14, 32'd2);
    expect_run(0);
    step();
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    expect_run(0);
    step();
    issue(32'hFFFF_FFF9, 32'd2, 1'b0, 1, 32'h7FFF_FFFC, 32'd1);
    expect_run(0);
    step();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1, 32'h8000_0000, 32'd0);
    expect_run(0);
    step();
    issue(32'h0000_1234, 32'd0, 1'b0, 1, 32'hFFFF_FFFF, 32'h0000_1234);
    expect_run(0);
    step();
    issue(32'hFFFF_FFF9, 32'd0, 1'b1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
    expect_run(0);
    step();

    // A start arriving mid-operation must be ignored.
    issue(32'd50, 32'd5, 1'b0, 1, 32'd10, 32'd0);
    expect_run(5);
    step();
    check("idle_after_poke", bus.busy, 1'b0);

    // Flush in iteration 10 cancels without a done pulse.
    issue(32'd9, 32'd4, 1'b0, 0, '0, '0);
    step();
    bus.start = 1'b0;
    for (int i = 2; i <= 10; i++) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_busy", bus.busy, 1'b0);
    check("flush_done", bus.done, 1'b0);
    check("flush_q", bus.q, 32'd10);
    check("flush_r", bus.r, 32'd0);

    issue(32'd9, 32'd4, 1'b0, 0, '0, '0);
    bus.flush = 1'b1;
    step();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush_start_busy", bus.busy, 1'b0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_idle_busy", bus.busy, 1'b0);
    check("flush_idle_q", bus.q, 32'd10);
    for (int i = 0; i < 40; i++) step();

    // Reset in iteration 20 clears results.
    issue(32'd123456, 32'd7, 1'b0, 0, '0, '0);
    step();
    bus.start = 1'b0;
    for (int i = 2; i <= 20; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_q", bus.q, 32'd0);
    check("midrst_r", bus.r, 32'd0);
    issue(32'd81, 32'd9, 1'b0, 1, 32'd9, 32'd0);
    expect_run(0);

    // Back-to-back: next start accepted in the done cycle.
    issue(32'd1000, 32'd33, 1'b0, 1, 32'd30, 32'd10);
    expect_run(0);
    issue(32'hFFFF_FF9C, 32'd7, 1'b1, 1, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    expect_run(0);
    step();

    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      logic        s;
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      s = i[0];
      e = model(a, b, s);
      issue(a, b, s, 1, e.q, e.r);
      expect_run(0);
    end
    step();
    step();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
